// File: rtl/hdmi_stream_out.sv
// Pixel-side HDMI streamer: raster timing generator that pops RGB565 words from a
// standard-mode FIFO, expands them to RGB888 and drives DE/HSYNC/VSYNC/RGB pins.
module hdmi_stream_out #(
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BP        = 220,
    parameter int V_ACTIVE    = 720,
    parameter int V_FP        = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 20,
    parameter int SYNC_POL    = 1,
    parameter int START_LEVEL = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [9:0]  fifo_count_i,
    input  logic [15:0] fifo_dout_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    output logic [23:0] rgb_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o,
    output logic        underflow_o,
    input  logic        underflow_clr_i,
    output logic [15:0] underflow_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]    START_L  = 10'(START_LEVEL);
    localparam logic          SYNC_INV = (SYNC_POL == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic active_p0, hs_p0, vs_p0, first_p0, frame_end_p0, underflow_p0;
    logic de_p1, hs_p1, vs_p1, first_p1, vld_p1;

    // MSB replication fills the low bits so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // Stage 0: raster decodes straight from the counters
    always_comb begin
        active_p0    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_p0        = (h_cnt >= H_SS) && (h_cnt < H_SE);
        vs_p0        = (v_cnt >= V_SS) && (v_cnt < V_SE);
        first_p0     = (h_cnt == '0) && (v_cnt == '0);
        frame_end_p0 = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        underflow_p0 = (state == ST_RUN) && active_p0 && fifo_empty_i;
    end

    assign fifo_rd_en_o = !reset_i && (state == ST_RUN) && active_p0 && !fifo_empty_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Decisions are taken on the wrap edge so the new state already governs pixel (0,0).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else if (underflow_p0) begin
            state <= ST_FILL;
        end else if (frame_end_p0) begin
            case (state)
                ST_IDLE: if (enable_i) state <= ST_FILL;
                ST_FILL: begin
                    if (!enable_i)                    state <= ST_IDLE;
                    else if (fifo_count_i >= START_L) state <= ST_RUN;
                end
                ST_RUN:  if (!enable_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end else if (underflow_p0) begin
            underflow_o <= 1'b1;
            if (underflow_clr_i)
                underflow_cnt_o <= 16'd1;
            else if (underflow_cnt_o != 16'hFFFF)
                underflow_cnt_o <= underflow_cnt_o + 16'd1;
        end else if (underflow_clr_i) begin
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end
    end

    // Stage 1: timing decodes travel with the pop that was issued
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            de_p1    <= 1'b0;
            hs_p1    <= 1'b0;
            vs_p1    <= 1'b0;
            first_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            de_p1    <= active_p0;
            hs_p1    <= hs_p0;
            vs_p1    <= vs_p0;
            first_p1 <= first_p0;
            vld_p1   <= fifo_rd_en_o;
        end
    end

    // Stage 2: pins; FIFO data lands here one cycle after the pop
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            de_o          <= 1'b0;
            hsync_o       <= SYNC_INV;
            vsync_o       <= SYNC_INV;
            rgb_o         <= '0;
            frame_start_o <= 1'b0;
        end else begin
            de_o          <= de_p1;
            hsync_o       <= hs_p1 ^ SYNC_INV;
            vsync_o       <= vs_p1 ^ SYNC_INV;
            rgb_o         <= vld_p1 ? rgb565_to_888(fifo_dout_i) : 24'h000000;
            frame_start_o <= de_p1 && first_p1 && vld_p1;
        end
    end

endmodule

// File: tb/tb_hdmi_stream_out.sv
// Directed bench for hdmi_stream_out on a 14x7 raster (98-cycle frame, START_LEVEL 16).
module tb_hdmi_stream_out;

    logic        clk = 1'b0;
    logic        reset_i, enable_i, fifo_empty_i, underflow_clr_i;
    logic [9:0]  fifo_count_i;
    logic [15:0] fifo_dout_i;
    logic        fifo_rd_en_o, de_o, hsync_o, vsync_o, frame_start_o, underflow_o;
    logic [23:0] rgb_o;
    logic [15:0] underflow_cnt_o;

    always #5 clk = ~clk;

    hdmi_stream_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .START_LEVEL(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .fifo_count_i(fifo_count_i), .fifo_dout_i(fifo_dout_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o), .rgb_o(rgb_o), .de_o(de_o), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .frame_start_o(frame_start_o), .underflow_o(underflow_o),
        .underflow_clr_i(underflow_clr_i), .underflow_cnt_o(underflow_cnt_o)
    );

    int t, vectors, errors, data_idx;
    int n_de, n_hs, n_vs, n_pop, n_fs, n_rgbnz;
    int s_de, s_hs, s_vs, s_pop, s_fs, s_rgbnz;
    logic pop_prev;
    logic [15:0] dat_tab [0:4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h8410};

    // One pixel clock; the FIFO model presents popped data the cycle after the pop.
    task automatic tick();
        pop_prev = fifo_rd_en_o;
        n_pop    += int'(fifo_rd_en_o);
        n_de     += int'(de_o);
        n_hs     += int'(hsync_o);
        n_vs     += int'(vsync_o);
        n_fs     += int'(frame_start_o);
        n_rgbnz  += int'(rgb_o != 24'h0);
        @(posedge clk);
        #1;
        t++;
        if (pop_prev) begin
            fifo_dout_i = (data_idx < 5) ? dat_tab[data_idx] : 16'hFFFF;
            data_idx++;
        end
    endtask

    task automatic go_to(input int target);
        while (t < target) tick();
    endtask

    task automatic snap();
        s_de = n_de; s_hs = n_hs; s_vs = n_vs; s_pop = n_pop; s_fs = n_fs; s_rgbnz = n_rgbnz;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_de"}, 32'(de_o), 32'h0);
        check({tag, "_rgb"}, 32'(rgb_o), 32'h0);
        check({tag, "_hs"}, 32'(hsync_o), 32'h0);
        check({tag, "_vs"}, 32'(vsync_o), 32'h0);
        check({tag, "_fs"}, 32'(frame_start_o), 32'h0);
        check({tag, "_uf"}, 32'(underflow_o), 32'h0);
        check({tag, "_ufcnt"}, 32'(underflow_cnt_o), 32'h0);
        check({tag, "_rden"}, 32'(fifo_rd_en_o), 32'h0);
    endtask

    initial begin
        vectors = 0; errors = 0; data_idx = 0; t = 0;
        n_de = 0; n_hs = 0; n_vs = 0; n_pop = 0; n_fs = 0; n_rgbnz = 0;
        snap();
        reset_i = 1'b1; enable_i = 1'b0; fifo_empty_i = 1'b1; underflow_clr_i = 1'b0;
        fifo_count_i = 10'd0; fifo_dout_i = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check_reset_pins("reset");
        reset_i = 1'b0;
        t = 0;

        // Raster timing: outputs trail the counter by two cycles
        go_to(2);  check("de_first", 32'(de_o), 32'h1);
        go_to(9);  check("de_h7", 32'(de_o), 32'h1);
        go_to(10); check("de_h8", 32'(de_o), 32'h0);
        go_to(11); check("hs_h9", 32'(hsync_o), 32'h0);
        go_to(12); check("hs_h10", 32'(hsync_o), 32'h1);
        go_to(13); check("hs_h11", 32'(hsync_o), 32'h1);
        go_to(14); check("hs_h12", 32'(hsync_o), 32'h0);
        go_to(71); check("vs_before", 32'(vsync_o), 32'h0);
        go_to(72); check("vs_start", 32'(vsync_o), 32'h1);
        go_to(85); check("vs_last", 32'(vsync_o), 32'h1);
        go_to(86); check("vs_after", 32'(vsync_o), 32'h0);
        go_to(98); snap();
        go_to(196);
        check("hs_per_frame", 32'(n_hs - s_hs), 32'd14);
        check("vs_per_frame", 32'(n_vs - s_vs), 32'd14);
        check("de_per_frame", 32'(n_de - s_de), 32'd32);
        check("idle_pops", 32'(n_pop - s_pop), 32'd0);

        // Start gating: below START_LEVEL nothing is read
        enable_i = 1'b1; fifo_count_i = 10'd10; fifo_empty_i = 1'b0;
        go_to(294); snap();
        go_to(450); fifo_count_i = 10'd16;
        go_to(490);
        check("fill_pops", 32'(n_pop - s_pop), 32'd0);
        check("fill_black", 32'(n_rgbnz - s_rgbnz), 32'd0);
        check("run_first_pop", 32'(fifo_rd_en_o), 32'h1);
        snap();
        go_to(491); check("fs_early", 32'(frame_start_o), 32'h0);
        go_to(492);
        check("fs_pulse", 32'(frame_start_o), 32'h1);
        check("fs_de", 32'(de_o), 32'h1);
        check("rgb_red", 32'(rgb_o), 32'hFF0000);
        go_to(493); check("rgb_green", 32'(rgb_o), 32'h00FF00);
        go_to(494); check("rgb_blue", 32'(rgb_o), 32'h0000FF);
        go_to(495); check("rgb_white", 32'(rgb_o), 32'hFFFFFF);
        go_to(496); check("rgb_8410", 32'(rgb_o), 32'h848284);
        go_to(588);
        check("run_pops", 32'(n_pop - s_pop), 32'd32);
        check("fs_count", 32'(n_fs - s_fs), 32'd1);
        snap();

        // Underflow at pixel 5 of this frame
        go_to(593);
        fifo_empty_i = 1'b1;
        #1;
        check("no_pop_empty", 32'(fifo_rd_en_o), 32'h0);
        check("uf_before", 32'(underflow_o), 32'h0);
        tick();
        fifo_empty_i = 1'b0;
        check("uf_flag", 32'(underflow_o), 32'h1);
        check("uf_cnt", 32'(underflow_cnt_o), 32'h1);
        check("pix4_white", 32'(rgb_o), 32'hFFFFFF);
        go_to(595);
        check("pix5_black", 32'(rgb_o), 32'h0);
        check("pix5_de", 32'(de_o), 32'h1);
        go_to(600); fifo_count_i = 10'd10;
        go_to(686);
        check("uf_frame_pops", 32'(n_pop - s_pop), 32'd5);
        snap();
        go_to(700); fifo_count_i = 10'd16;
        go_to(784);
        check("refill_pops", 32'(n_pop - s_pop), 32'd0);
        snap();
        go_to(799);
        check("uf_sticky", 32'(underflow_o), 32'h1);
        check("uf_cnt_hold", 32'(underflow_cnt_o), 32'h1);
        go_to(800);
        underflow_clr_i = 1'b1;
        tick();
        underflow_clr_i = 1'b0;
        check("uf_cleared", 32'(underflow_o), 32'h0);
        check("uf_cnt_cleared", 32'(underflow_cnt_o), 32'h0);
        go_to(882);
        check("rerun_pops", 32'(n_pop - s_pop), 32'd32);
        snap();

        // Disable mid-frame: current frame completes, then idle
        go_to(900); enable_i = 1'b0;
        go_to(980);
        check("disable_frame_pops", 32'(n_pop - s_pop), 32'd32);
        snap();
        go_to(1000); enable_i = 1'b1;
        go_to(1078);
        check("idle_after_disable", 32'(n_pop - s_pop), 32'd0);

        // Reset mid-line while streaming
        go_to(1180);
        check("pre_reset_pop", 32'(fifo_rd_en_o), 32'h1);
        reset_i = 1'b1;
        #1;
        check("reset_cycle_pop", 32'(fifo_rd_en_o), 32'h0);
        tick();
        check_reset_pins("midreset");
        reset_i = 1'b0;
        t = 0;
        go_to(1); check("restart_de0", 32'(de_o), 32'h0);
        go_to(2);
        check("restart_de1", 32'(de_o), 32'h1);
        check("restart_black", 32'(rgb_o), 32'h0);
        check("restart_nopop", 32'(fifo_rd_en_o), 32'h0);
        go_to(12); check("restart_hs", 32'(hsync_o), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_stream_out.md
# hdmi_stream_out

Pixel-side consumer of the HDMI FIFO that `bram_memory_controller` fills. It free-runs a parameterised raster timing generator and pops one RGB565 word per active pixel from the FIFO in standard (non-FWFT) read mode. It expands each word to RGB888 and drives DE/HSYNC/VSYNC/RGB towards the HDMI encoder. It also gates frame start on FIFO fill level and reports underflow.

## Interface
- `H_ACTIVE`, 1280: active pixels per line
- `H_FP`, 110; `H_SYNC`, 40; `H_BP`, 220: horizontal front porch / sync / back porch, in pixels
- `V_ACTIVE`, 720: active lines
- `V_FP`, 5; `V_SYNC`, 5; `V_BP`, 20: vertical porches / sync, in lines
- `SYNC_POL`, 1: 1 = syncs active-high, 0 = active-low
- `START_LEVEL`, 256: minimum FIFO count required to start a frame
- `clk_i` in 1: pixel clock; the block's only clock
- `reset_i` in 1: synchronous, active-high reset
- `enable_i` in 1: permit streaming
- `fifo_count_i` in 10: HDMI FIFO read-side data count
- `fifo_dout_i` in 16: RGB565 data, valid the cycle after `fifo_rd_en_o`
- `fifo_empty_i` in 1: HDMI FIFO empty
- `fifo_rd_en_o` out 1: FIFO pop
- `rgb_o` out 24: {R8,G8,B8}
- `de_o`, `hsync_o`, `vsync_o` out 1: video timing
- `frame_start_o` out 1: one-cycle pulse, aligned with the first pixel of a frame at the pins
- `underflow_o` out 1: sticky underflow flag
- `underflow_clr_i` in 1: clears `underflow_o` and `underflow_cnt_o`
- `underflow_cnt_o` out 16: missed pixels, saturating at 0xFFFF

## Operation
- **Counters.** `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of H_*. `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps. Both wrap to 0. Counters free-run from reset regardless of state.
- **Stage-0 decodes.**
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs uses the same rule on `v_cnt`.
  - Sync outputs are XORed with !SYNC_POL.
- **State machine.** Transitions are evaluated only at the frame boundary (h_cnt==0 && v_cnt==0), except the underflow abort.
  - IDLE: no reads. At the boundary, go to FILL if `enable_i`=1.
  - FILL: no reads. At the boundary: if `enable_i`=0, go to IDLE; else if `fifo_count_i` ≥ START_LEVEL, go to RUN.
  - RUN: `fifo_rd_en_o` = active && !`fifo_empty_i` (combinational from stage-0).
    - Underflow occurs when active && `fifo_empty_i` in RUN. The pixel is output as black, `underflow_cnt_o` increments, `underflow_o` sets, and the state goes to FILL immediately, so the rest of that frame is black with no reads.
    - At the boundary with `enable_i`=0, go to IDLE.
- **Output path.**
  - Stage 1 registers the stage-0 decodes and a pix_valid bit (= the `fifo_rd_en_o` issued).
  - Stage 2 registers the outputs:
    - `de_o`: from stage 1.
    - `rgb_o`: the expansion of `fifo_dout_i` if pix_valid, else 0.
    - `hsync_o`, `vsync_o`: from stage 1.
    - `frame_start_o` = stage-1 de at (h=0, v=0) && pix_valid.
- **Colour expansion.** MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. Example: 0xFFFF→0xFFFFFF, 0xF800→0xFF0000, 0x0000→0x000000.
- **Reset.** All outputs are 0, except `hsync_o`/`vsync_o`, which take their inactive level (= !SYNC_POL). Counters are 0, state is IDLE, `underflow_cnt_o` is 0. Reset mid-frame truncates the frame; no pops are issued in the reset cycle.
- **Clearing.** `underflow_clr_i` clears the flag and count; an underflow in the same cycle wins (flag=1, cnt=1).
- **Data ownership.** The block never flushes the FIFO. Frame alignment after underflow is the writer's responsibility.

## Timing
- Pipeline latency is 2 cycles from counter to pins, identical for DE, syncs and RGB, so they stay mutually aligned.
- Pop handshake: `fifo_rd_en_o` high in cycle t ⇒ `fifo_dout_i` is sampled at the end of t+1 ⇒ `rgb_o` is valid in t+2.
- Exactly H_ACTIVE×V_ACTIVE pops per complete RUN frame; pops never occur outside active.
- `fifo_rd_en_o` is never high while `fifo_empty_i`=1.
- `enable_i` deassertion mid-frame is honoured only at the next boundary; the current frame completes.

## Test plan
- **Small raster.** Parameters H 8/2/2/2, V 4/1/1/1 (total 14×7). Check: `hsync_o` high for 2 of every 14 cycles; `vsync_o` high for 14 cycles per 98; `de_o` 32 cycles per frame; all three aligned.
- **Start gating and pop count.** `enable_i`=1, count=10 with START_LEVEL=16 → no pops and black output. Raise count to 16 → RUN from the next boundary. Check 32 pops per frame and `frame_start_o` coinciding with the first DE.
- **Data path.** Feed 0xF800, 0x07E0, 0x001F, 0xFFFF. Check `rgb_o` = FF0000, 00FF00, 0000FF, FFFFFF, each 2 cycles after the corresponding pop.
- **Underflow.** Assert empty at pixel 5 of frame 1. Check: pixel 5 black; `underflow_o`=1; cnt=1; no further pops that frame; FILL, then RUN again at a later boundary once count ≥ START_LEVEL. Then pulse `underflow_clr_i` → flag and count return to 0.
- **Disable and reset.** Drop `enable_i` mid-frame → pops continue to frame end, then IDLE. Assert `reset_i` mid-line → next cycle all outputs at reset values and no pop; counters restart from 0.
